matmul_acc: RTL and testbench

- Next-generation matrix multiplier: computes M3 = M1 x M2^T (A x C outputs, B-long dot products), or M3 += M1 x M2^T in accumulate mode.
- Element type selectable per run: signed or unsigned.
- Results go to a parametrised output width with saturation instead of silent truncation, and each run is launched by an explicit start handshake.
- Sits between two block_rom operand memories and one block_ram result memory; in accumulate mode it also reads that result memory.

---
 rtl/matmul_acc.sv | 124 ++++++++++++
 tb/tb_matmul_acc.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/matmul_acc.sv
// matmul_acc: three-stage M1 x M2^T multiplier with optional accumulate and saturating output
module matmul_acc #(
  parameter int A        = 16,
  parameter int B        = 32,
  parameter int C        = 24,
  parameter int BITS     = 8,
  parameter int OUT_BITS = BITS * 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     start,
  input  logic                     signed_en,
  input  logic                     accum_en,
  output logic [$clog2(A)-1:0]     m1_addr,
  input  logic [B*BITS-1:0]        m1_data,
  output logic [$clog2(C)-1:0]     m2_addr,
  input  logic [B*BITS-1:0]        m2_data,
  output logic [$clog2(A*C)-1:0]   m3_rd_addr,
  input  logic [OUT_BITS-1:0]      m3_rd_data,
  output logic [$clog2(A*C)-1:0]   m3_wr_addr,
  output logic [OUT_BITS-1:0]      m3_wr_data,
  output logic                     m3_wr_ena,
  output logic                     busy,
  output logic                     valid
);
  localparam int FULL_BITS = 2 * BITS + $clog2(B) + 1;
  localparam int PB = 2 * BITS;
  localparam int W = (OUT_BITS > FULL_BITS ? OUT_BITS : FULL_BITS) + 1;
  localparam int RW = $clog2(A);
  localparam int CW = $clog2(C);
  localparam int AW = $clog2(A * C);
  localparam logic [W-1:0] SMAX = (W'(1) << (OUT_BITS - 1)) - W'(1);
  localparam logic [W-1:0] SMIN = ~SMAX;
  localparam logic [W-1:0] UMAX = (W'(1) << OUT_BITS) - W'(1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;
  state_t state_q, state_d;
  logic sgn_q, sgn_d, acc_q, acc_d;
  logic [RW-1:0] r_q, r_d;
  logic [CW-1:0] c_q, c_d;
  logic [AW-1:0] idx_q, idx_d, a0_q, a1_q, wa_q;
  logic take, last_issue, last_wr, row_end;
  logic v0_q, v1_q, wv_q;
  logic [B-1:0][PB-1:0] prod_d, prod_q;
  logic [FULL_BITS-1:0] sum_d, sum_q;
  logic [OUT_BITS-1:0] rd_q, wd_d, wd_q;
  logic [W-1:0] acc_w;
  assign take       = start && (state_q == IDLE || state_q == DONE);
  assign row_end    = state_q == RUN && c_q == CW'(C - 1);
  assign last_issue = row_end && r_q == RW'(A - 1);
  assign last_wr    = wv_q && wa_q == AW'(A * C - 1);
  always_comb begin
    state_d = take ? RUN : last_issue ? DRAIN : (state_q == DRAIN && last_wr) ? DONE : state_q;
    sgn_d   = take ? signed_en : sgn_q;
    acc_d   = take ? accum_en : acc_q;
    c_d     = (take || row_end) ? '0 : state_q == RUN ? c_q + 1'b1 : c_q;
    r_d     = (take || last_issue) ? '0 : row_end ? r_q + 1'b1 : r_q;
    idx_d   = (take || last_issue) ? '0 : state_q == RUN ? idx_q + 1'b1 : idx_q;
  end
  // Extending both operands to 2*BITS before multiplying yields the exact product in either mode
  for (genvar k = 0; k < B; k++) begin : g_mul
    logic [PB-1:0] x, y;
    assign x = {{BITS{sgn_q & m1_data[k*BITS+BITS-1]}}, m1_data[k*BITS +: BITS]};
    assign y = {{BITS{sgn_q & m2_data[k*BITS+BITS-1]}}, m2_data[k*BITS +: BITS]};
    assign prod_d[k] = x * y;
  end
  always_comb begin
    sum_d = '0;
    for (int k = 0; k < B; k++)
      sum_d = sum_d + {{(FULL_BITS-PB){sgn_q & prod_q[k][PB-1]}}, prod_q[k]};
  end
  // One guard bit above the wider operand keeps the accumulate sum exact before clamping
  always_comb begin
    acc_w = {{(W-FULL_BITS){sgn_q & sum_q[FULL_BITS-1]}}, sum_q}
          + (acc_q ? {{(W-OUT_BITS){sgn_q & rd_q[OUT_BITS-1]}}, rd_q} : '0);
    wd_d  = OUT_BITS'(sgn_q ? ($signed(acc_w) > $signed(SMAX) ? SMAX :
                               $signed(acc_w) < $signed(SMIN) ? SMIN : acc_w)
                            : (acc_w > UMAX ? UMAX : acc_w));
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      sgn_q   <= 1'b0;
      acc_q   <= 1'b0;
      r_q     <= '0;
      c_q     <= '0;
      idx_q   <= '0;
      v0_q    <= 1'b0;
      a0_q    <= '0;
      prod_q  <= '0;
      v1_q    <= 1'b0;
      a1_q    <= '0;
      sum_q   <= '0;
      rd_q    <= '0;
      wv_q    <= 1'b0;
      wa_q    <= '0;
      wd_q    <= '0;
    end else begin
      state_q <= state_d;
      sgn_q   <= sgn_d;
      acc_q   <= acc_d;
      r_q     <= r_d;
      c_q     <= c_d;
      idx_q   <= idx_d;
      v0_q    <= state_q == RUN;
      a0_q    <= idx_q;
      prod_q  <= prod_d;
      v1_q    <= v0_q;
      a1_q    <= a0_q;
      sum_q   <= sum_d;
      rd_q    <= m3_rd_data;
      wv_q    <= v1_q;
      wa_q    <= a1_q;
      wd_q    <= wd_d;
    end
  end
  assign m1_addr    = r_q;
  assign m2_addr    = c_q;
  assign m3_rd_addr = idx_q;
  assign m3_wr_addr = wa_q;
  assign m3_wr_data = wd_q;
  assign m3_wr_ena  = wv_q;
  assign busy       = state_q == RUN || state_q == DRAIN;
  assign valid      = state_q == DONE;
endmodule

// File: tb/tb_matmul_acc.sv
// tb_matmul_acc: directed checks of matmul_acc with behavioural ROMs and result RAMs
module tb_matmul_acc;
  localparam int A = 16, B = 32, C = 24, BITS = 8, N = A * C;
  logic clk = 1'b0, rst = 1'b1;
  always #5 clk = ~clk;
  logic start = 1'b0, start_s = 1'b0, sgn = 1'b0, acc = 1'b0;
  logic [3:0] m1_addr, m1_addr_s;
  logic [4:0] m2_addr, m2_addr_s;
  logic [8:0] m3_rd_addr, m3_wr_addr, m3_rd_addr_s, m3_wr_addr_s;
  logic [31:0] m3_rd_data = '0, m3_wr_data;
  logic [15:0] m3_rd_data_s = '0, m3_wr_data_s;
  logic m3_wr_ena, busy, valid, m3_wr_ena_s, busy_s, valid_s;
  logic [B*BITS-1:0] m1_mem [A];
  logic [B*BITS-1:0] m2_mem [C];
  logic [31:0] mem [N];
  logic [15:0] mems [N];
  int wcnt [N];
  int strobes = 0;
  logic pre_en = 1'b0;
  logic [31:0] pre_val = '0;
  int tests = 0, fails = 0;

  matmul_acc u_dut (
    .clk(clk), .rst(rst), .start(start), .signed_en(sgn), .accum_en(acc),
    .m1_addr(m1_addr), .m1_data(m1_mem[m1_addr]), .m2_addr(m2_addr), .m2_data(m2_mem[m2_addr]),
    .m3_rd_addr(m3_rd_addr), .m3_rd_data(m3_rd_data), .m3_wr_addr(m3_wr_addr),
    .m3_wr_data(m3_wr_data), .m3_wr_ena(m3_wr_ena), .busy(busy), .valid(valid));

  matmul_acc #(.OUT_BITS(16)) u_sat (
    .clk(clk), .rst(rst), .start(start_s), .signed_en(sgn), .accum_en(acc),
    .m1_addr(m1_addr_s), .m1_data(m1_mem[m1_addr_s]), .m2_addr(m2_addr_s), .m2_data(m2_mem[m2_addr_s]),
    .m3_rd_addr(m3_rd_addr_s), .m3_rd_data(m3_rd_data_s), .m3_wr_addr(m3_wr_addr_s),
    .m3_wr_data(m3_wr_data_s), .m3_wr_ena(m3_wr_ena_s), .busy(busy_s), .valid(valid_s));

  initial for (int i = 0; i < N; i++) wcnt[i] = 0;

  always @(posedge clk) begin
    m3_rd_data <= mem[m3_rd_addr];
    if (pre_en) begin
      for (int i = 0; i < N; i++) mem[i] <= pre_val;
    end else if (m3_wr_ena) begin
      mem[m3_wr_addr] <= m3_wr_data;
      wcnt[m3_wr_addr] <= wcnt[m3_wr_addr] + 1;
      strobes <= strobes + 1;
    end
  end

  always @(posedge clk) begin
    m3_rd_data_s <= mems[m3_rd_addr_s];
    if (m3_wr_ena_s) mems[m3_wr_addr_s] <= m3_wr_data_s;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 'h%0h expected 'h%0h", tag, got, exp);
    end
  endtask

  task automatic fill(input logic [7:0] a, input logic [7:0] b, input logic ident);
    for (int r = 0; r < A; r++) m1_mem[r] = ident ? {B{8'h01}} : {B{a}};
    for (int c = 0; c < C; c++) m2_mem[c] = ident ? {B{8'(c)}} : {B{b}};
  endtask

  task automatic preload(input logic [31:0] v);
    @(negedge clk);
    pre_val = v;
    pre_en = 1'b1;
    @(negedge clk);
    pre_en = 1'b0;
  endtask

  task automatic chk_mem(input string tag, input int k1, input int k0);
    int bad = 0;
    for (int r = 0; r < A; r++)
      for (int c = 0; c < C; c++)
        if (mem[r*C+c] !== 32'(k1 * c + k0)) bad++;
    chk(tag, bad, 0);
  endtask

  task automatic run(input logic s, input logic a, input logic sat, input int pulse_at, input string tag);
    int n, s0, bad;
    int w0 [N];
    logic wr2, wr3, done;
    s0 = strobes;
    for (int i = 0; i < N; i++) w0[i] = wcnt[i];
    @(negedge clk);
    sgn = s;
    acc = a;
    if (sat) start_s = 1'b1; else start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    start_s = 1'b0;
    chk({tag, "_busy"}, 32'(sat ? busy_s : busy), 32'd1);
    chk({tag, "_vdrop"}, 32'(sat ? valid_s : valid), 32'd0);
    n = 0;
    done = 1'b0;
    wr2 = 1'b1;
    wr3 = 1'b0;
    while (!done && n < 2000) begin
      @(posedge clk);
      @(negedge clk);
      n++;
      start = (n == pulse_at);
      if (n == 2) wr2 = m3_wr_ena;
      if (n == 3) wr3 = m3_wr_ena;
      done = sat ? valid_s : valid;
    end
    start = 1'b0;
    chk({tag, "_lat"}, n, 387);
    if (!sat) begin
      chk({tag, "_first_wr"}, 32'({wr2, wr3}), 32'd1);
      chk({tag, "_strobes"}, strobes - s0, N);
      bad = 0;
      for (int i = 0; i < N; i++) if (wcnt[i] - w0[i] != 1) bad++;
      chk({tag, "_once"}, bad, 0);
    end
  endtask

  initial begin
    int s0, n;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_wr_ena", 32'(m3_wr_ena), 32'd0);
    chk("rst_m1_addr", 32'(m1_addr), 32'd0);
    chk("rst_rd_addr", 32'(m3_rd_addr), 32'd0);
    rst = 1'b1;

    fill(8'h00, 8'h00, 1'b1);
    preload(32'd0);
    run(1'b0, 1'b0, 1'b0, 0, "id");
    chk_mem("id_all", 32, 0);
    chk("id_5_3", mem[5*C+3], 32'd96);

    preload(32'hDEAD);
    run(1'b0, 1'b0, 1'b0, 50, "hs");
    chk_mem("hs_all", 32, 0);

    fill(8'h80, 8'h80, 1'b0);
    run(1'b1, 1'b0, 1'b0, 0, "s80");
    chk_mem("s80_all", 0, 524288);
    run(1'b0, 1'b0, 1'b0, 0, "u80");
    chk_mem("u80_all", 0, 524288);
    fill(8'h80, 8'h01, 1'b0);
    run(1'b0, 1'b0, 1'b0, 0, "u01");
    chk_mem("u01_all", 0, 4096);
    run(1'b1, 1'b0, 1'b0, 0, "s01");
    chk_mem("s01_all", 0, -4096);
    chk("s01_0", mem[0], 32'hFFFF_F000);

    fill(8'h00, 8'h00, 1'b1);
    preload(32'd10);
    run(1'b0, 1'b1, 1'b0, 0, "acc1");
    chk_mem("acc1_all", 32, 10);
    chk("acc1_5_3", mem[5*C+3], 32'd106);
    run(1'b0, 1'b1, 1'b0, 0, "acc2");
    chk_mem("acc2_all", 64, 10);
    chk("acc2_5_3", mem[5*C+3], 32'd202);

    fill(8'hFF, 8'hFF, 1'b0);
    run(1'b0, 1'b0, 1'b1, 0, "satu");
    chk("satu_0", 32'(mems[0]), 32'd65535);
    chk("satu_last", 32'(mems[N-1]), 32'd65535);
    fill(8'h7F, 8'h80, 1'b0);
    run(1'b1, 1'b0, 1'b1, 0, "sats");
    chk("sats_0", 32'(mems[0]), 32'h8000);
    chk("sats_last", 32'(mems[N-1]), 32'h8000);
    fill(8'h00, 8'h00, 1'b1);
    run(1'b0, 1'b0, 1'b1, 0, "satid");
    chk("satid_5_3", 32'(mems[5*C+3]), 32'd96);

    preload(32'd0);
    s0 = strobes;
    @(negedge clk);
    sgn = 1'b0;
    acc = 1'b0;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n = 0;
    while (strobes - s0 < 100 && n < 1000) begin
      @(negedge clk);
      n++;
    end
    chk("mid_reached", strobes - s0, 100);
    chk("mid_pre_wr", 32'(m3_wr_ena), 32'd1);
    rst = 1'b0;
    #1;
    chk("mid_wr_ena", 32'(m3_wr_ena), 32'd0);
    chk("mid_busy", 32'(busy), 32'd0);
    chk("mid_m1_addr", 32'(m1_addr), 32'd0);
    chk("mid_wr_addr", 32'(m3_wr_addr), 32'd0);
    s0 = strobes;
    repeat (5) @(negedge clk);
    chk("mid_no_wr", strobes - s0, 0);
    rst = 1'b1;
    run(1'b0, 1'b0, 1'b0, 0, "post");
    chk_mem("post_all", 32, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
